// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit for the execute stage. Accepts one op,
// runs a shift-add multiply or restoring divide on operand magnitudes over
// 32/STEPS_PER_CYCLE cycles, fixes the sign in one extra cycle, and returns
// the result with its destination register as a one-cycle done pulse.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             issue request; honoured only in IDLE or DONE
//   op[2:0]           0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   operand_a/b[31:0] rs1 / rs2 values
//   rd_in[4:0]        destination register of the issued op
//   flush             abort any op in progress; no done follows
//   busy              combinational stall request to the hazard logic
//   done              one-cycle result-valid pulse
//   result[31:0]      final result, held until the next completion
//   rd_out[4:0]       destination register paired with result
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    localparam int N = 32 / STEPS_PER_CYCLE;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [31:0] acc_hi;    // product high word / partial remainder
    logic [31:0] acc_lo;    // multiplier being consumed / quotient being built
    logic        neg_q;     // final result must be negated in FIX

    // ---------------- issue-time decode ----------------
    logic        a_signed, b_signed, sa, sb, neg_issue;
    logic [31:0] a_mag, b_mag;
    logic        is_div, div_zero, div_ovf, early_hit;
    logic [31:0] early_result;

    assign is_div    = op[2];
    assign a_signed  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sa        = a_signed && operand_a[31];
    assign sb        = b_signed && operand_b[31];
    assign a_mag     = sa ? (~operand_a + 32'd1) : operand_a;
    assign b_mag     = sb ? (~operand_b + 32'd1) : operand_b;
    // Remainder takes the dividend's sign; product and quotient take sa^sb.
    assign neg_issue = (is_div && op[1]) ? sa : (sa ^ sb);

    assign div_zero  = is_div && (operand_b == 32'd0);
    assign div_ovf   = is_div && !op[0] && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    assign early_hit = div_zero || div_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        early_result = 32'd0;
        if (div_zero)
            early_result = op[1] ? operand_a : 32'hFFFF_FFFF;
        else if (div_ovf)
            early_result = op[1] ? 32'd0 : 32'h8000_0000;
    end

    // ---------------- iteration datapath ----------------
    logic [31:0] step_hi, step_lo;
    logic [32:0] rs, sum;
    logic        qbit;

    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        rs      = 33'd0;
        sum     = 33'd0;
        qbit    = 1'b0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                // Restoring divide: bring in the next dividend bit, try the subtract.
                rs   = {step_hi, step_lo[31]};
                qbit = (rs >= {1'b0, opnd});
                if (qbit)
                    rs = rs - {1'b0, opnd};
                step_hi = rs[31:0];
                step_lo = {step_lo[30:0], qbit};
            end else begin
                // Shift-add multiply: conditionally add, then shift the 65-bit pair right.
                sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd} : 33'd0);
                step_lo = {sum[0], step_lo[31:1]};
                step_hi = sum[32:1];
            end
        end
    end

    // ---------------- sign fix and result select ----------------
    logic [63:0] prod_f;
    logic [31:0] quot_f, rem_f, fix_result;

    assign prod_f = neg_q ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    assign quot_f = neg_q ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_f  = neg_q ? (~acc_hi + 32'd1) : acc_hi;

    always_comb begin
        fix_result = prod_f[63:32];
        if (op_q == OP_MUL)
            fix_result = prod_f[31:0];
        else if (op_q[2])
            fix_result = op_q[1] ? rem_f : quot_f;
    end

    assign busy = (start && (state == S_IDLE || state == S_DONE))
               || (state == S_CALC) || (state == S_FIX);

    // ---------------- control ----------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= 5'd0;
            op_q   <= 3'd0;
            rd_q   <= 5'd0;
            opnd   <= 32'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            neg_q  <= 1'b0;
            result <= 32'd0;
            rd_out <= 5'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            op_q <= op;
                            rd_q <= rd_in;
                            if (early_hit) begin
                                result <= early_result;
                                rd_out <= rd_in;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                opnd   <= is_div ? b_mag : a_mag;
                                acc_lo <= is_div ? a_mag : b_mag;
                                acc_hi <= 32'd0;
                                neg_q  <= neg_issue;
                                count  <= 5'(N - 1);
                                state  <= S_CALC;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        if (count == 5'd0)
                            state <= S_FIX;
                        else
                            count <= count - 5'd1;
                    end
                    S_FIX: begin
                        result <= fix_result;
                        rd_out <= rd_q;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Directed-vector bench for muldiv_sequencer (STEPS_PER_CYCLE=1, N=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.STEPS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: present the op for one cycle, return just after the edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        #1;
        check("busy_on_issue", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done; checks latency, busy span, result and rd_out. Returns at the done falling edge.
    task automatic wait_done(input string tag, input int exp_cyc, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd);
        int cyc = 0;
        int busy_cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done) break;
            if (busy) busy_cyc++;
            if (cyc >= 100) break;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_span"}, 32'(busy_cyc), 32'(exp_cyc - 1));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_rd"}, 32'(rd_out), 32'(exp_rd));
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res,
                       input bit early);
        issue(o, a, b, rd);
        wait_done(tag, early ? 1 : N + 2, exp_res, rd);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic        saw_done;
        logic [31:0] held;

        // Reset state
        #2;
        check("reset_result", result, 32'd0);
        check("reset_rd", 32'(rd_out), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Multiply family
        run("mul",    3'd0, 32'd7,        32'd6,        5'd3,  32'd42,        1'b0);
        run("mulh",   3'd1, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF,  1'b0);
        run("mulhu",  3'd3, 32'hFFFFFFFF, 32'd2,        5'd5,  32'h00000001,  1'b0);
        run("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF,  1'b0);

        // Divide family
        run("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD,  1'b0);
        run("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF,  1'b0);
        run("divu",   3'd5, 32'd100,      32'd7,        5'd9,  32'd14,        1'b0);
        run("remu",   3'd7, 32'd100,      32'd7,        5'd10, 32'd2,         1'b0);
        run("div_min",3'd4, 32'h80000000, 32'd2,        5'd11, 32'hC0000000,  1'b0);

        // Early-outs
        run("divu_z", 3'd5, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF,  1'b1);
        run("rem_z",  3'd6, 32'd5,        32'd0,        5'd13, 32'd5,         1'b1);
        run("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000,  1'b1);
        run("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,         1'b1);

        // Flush during CALC: back to IDLE, no done, result held (0 from rem_ov)
        held = result;
        issue(3'd0, 32'd11, 32'd13, 5'd20);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_drop", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("flush_no_done", 32'(saw_done), 32'd0);
        check("flush_result_held", result, held);

        // flush and start together: busy asserted, op not accepted
        start = 1'b1; flush = 1'b1; op = 3'd5; operand_a = 32'd9; operand_b = 32'd0; rd_in = 5'd21;
        #1;
        check("flush_start_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_start_idle", 32'(busy), 32'd0);
        check("flush_start_no_done", 32'(done), 32'd0);

        // Back-to-back: start in the DONE cycle chains straight into CALC
        @(negedge clk);
        issue(3'd5, 32'd100, 32'd7, 5'd22);
        wait_done("chain1", N + 2, 32'd14, 5'd22);
        issue(3'd0, 32'd5, 32'd5, 5'd23);
        wait_done("chain2", N + 2, 32'd25, 5'd23);
        @(negedge clk);

        // Async reset mid-CALC: outputs clear immediately, no done afterwards
        issue(3'd0, 32'd2, 32'd2, 5'd24);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_rd", 32'(rd_out), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        run("mul_after_rst", 3'd0, 32'd3, 32'd3, 5'd25, 32'd9, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the execute stage; implements the RV32M ops the single-cycle ALU lacks.
- Accepts one operation from EX, then runs a shift-add multiply or restoring divide over several cycles.
- Drives a stall request to the hazard logic, then returns one result with its destination register to EX/MEM.

Parameters:
- STEPS_PER_CYCLE, default 1: iteration steps done per clock. Legal values are 1, 2, 4. Sets N = 32/STEPS_PER_CYCLE compute cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request from EX; sampled only in IDLE or DONE
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- operand_a  input  32  rs1 value, already forwarded
- operand_b  input  32  rs2 value, already forwarded
- rd_in  input  5  destination register of the issued op
- flush  input  1  pipeline flush; aborts any operation in progress
- busy  output  1  stall request to the pipeline
- done  output  1  one-cycle result-valid pulse
- result  output  32  final result
- rd_out  output  5  destination register that goes with result

Behaviour:
- States: IDLE, CALC, FIX, DONE. Encoding is free.
- Reset (async, rst_n=0): state IDLE; result=0, rd_out=0, done=0, busy=0; internal counter and accumulators cleared. Reset mid-operation discards the operation; no done follows.
- Issue (start=1 in IDLE or DONE, flush=0): on that edge, latch op, rd_in, |a|, |b|, and sign flags.
  - Signed ops: DIV, REM, MULH use both signs. MULHSU: only a is signed.
  - Next state is CALC, with the counter loaded to N-1.
- Early-out at issue, which goes straight to DONE on the same edge:
  - Divide-class op with b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV with a=0x80000000 and b=0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0.
- CALC:
  - Each cycle performs STEPS_PER_CYCLE steps. Multiply is shift-add into a 64-bit product. Divide is restoring: shift the remainder, subtract, set the quotient bit.
  - Counter at 0 means the next state is FIX.
- FIX: one cycle. Negate the 64-bit product, quotient, or remainder as required.
  - Product sign = sa^sb.
  - Quotient sign = sa^sb.
  - Remainder sign = sa.
  - Select the low word (MUL), high word (MULH*), quotient, or remainder into result. Next state is DONE.
- DONE: done=1 for exactly one cycle; result and rd_out are valid.
  - Next state is IDLE, or CALC if a new start is accepted.
  - result and rd_out hold their values until the next FIX or early-out.
- busy = start&&(state IDLE or DONE) || state CALC || state FIX. It is combinational, so the issuing instruction stalls in its own cycle. busy=0 in DONE unless a new start arrives.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+N+1. That is N+2 cycles; default 34. Early-outs give done in the cycle after edge k.
- start arriving in CALC or FIX is ignored.
- flush=1 in any state: next state IDLE; no done pulse; result and rd_out unchanged.
- flush and start in the same cycle: flush wins and the op is not accepted. busy is still asserted that cycle.
- All arithmetic is unsigned on magnitudes. Negating |0x80000000| yields 0x80000000 with no overflow flag.

Test Plan:
- MUL a=7, b=6, STEPS=1: busy high for 34 cycles from start; done pulse in cycle 34; result=42; rd_out equals rd_in.
- MULH a=0xFFFFFFFF (-1), b=2: result=0xFFFFFFFF. MULHU with the same operands gives 0x00000001. MULHSU a=-1, b=0xFFFFFFFF gives 0xFFFFFFFF.
- DIV a=-7, b=2 gives 0xFFFFFFFD (-3). REM with the same operands gives 0xFFFFFFFF (-1). DIVU a=100, b=7 gives 14. REMU with the same operands gives 2.
- Divide by zero: DIVU a=5, b=0 gives done one cycle after start with 0xFFFFFFFF. REM a=5, b=0 gives 5. Overflow: DIV 0x80000000/-1 gives 0x80000000 with early done.
- flush at CALC cycle 10: returns to IDLE; no done; busy drops. A start issued in the DONE cycle chains back-to-back with no idle gap.
- rst_n low at CALC cycle 5: outputs immediately 0. After release, a new MUL 3×3 completes normally with result=9.
